alu_sequencer: RTL and testbench

//   Multi-cycle control/datapath stage directly upstream of the ALU.
//   - Accepts one instruction word per handshake.
//   - Reads operands from an internal 8-entry register file and drives the ALU en/a/b/op inputs.
//   - Captures the ALU result and writes it back to the destination register.
//   - Forms the execute loop of the simple processor together with the ALU.

---
 rtl/alu_sequencer_if.sv | 66 ++++++
 rtl/alu_sequencer.sv | 143 ++++++++++++++
 tb/tb_alu_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer_if
// Purpose  : Instruction handshake, ALU drive/return and debug read bundle
//            for alu_sequencer. Flag outputs exist only when FLAGS_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_sequencer_if #(
    parameter int N = 16
);
    logic [15:0]  instr;
    logic         instr_valid;
    logic         instr_ready;
    logic         alu_en;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [2:0]   alu_op;
    logic [N-1:0] alu_out;
    logic         done;
    logic [2:0]   dbg_addr;
    logic [N-1:0] dbg_data;
`ifdef FLAGS_EN
    logic         flag_z;
    logic         flag_n;
`endif

    // Sequencer side
    modport master (
        input  instr,
        input  instr_valid,
        input  alu_out,
        input  dbg_addr,
`ifdef FLAGS_EN
        output flag_z,
        output flag_n,
`endif
        output instr_ready,
        output alu_en,
        output alu_a,
        output alu_b,
        output alu_op,
        output done,
        output dbg_data
    );

    // Instruction source / ALU / debug side
    modport slave (
        output instr,
        output instr_valid,
        output alu_out,
        output dbg_addr,
`ifdef FLAGS_EN
        input  flag_z,
        input  flag_n,
`endif
        input  instr_ready,
        input  alu_en,
        input  alu_a,
        input  alu_b,
        input  alu_op,
        input  done,
        input  dbg_data
    );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Multi-cycle IDLE/READ/EXEC/WB control stage in front of an
//            external ALU. Holds an 8-entry register file, drives the ALU
//            operands for one EXEC cycle and writes the result back.
//            Optional feature macro: FLAGS_EN (adds zero/negative flags).
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int N    = 16,
    parameter int REGS = 8
) (
    input wire              clk,
    input wire              rst,
    alu_sequencer_if.master bus
);

    // Opcode values that bypass the ALU
    localparam logic [2:0] c_OP_NOP = 3'b000;
    localparam logic [2:0] c_OP_LDI = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t       state_q;
    logic [15:0]  ir_q;
    logic [N-1:0] alu_a_q;
    logic [N-1:0] alu_b_q;
    logic [2:0]   alu_op_q;
    logic [N-1:0] result_q;
    logic [N-1:0] rf_q [REGS];
`ifdef FLAGS_EN
    logic         flag_z_q;
    logic         flag_n_q;
`endif

    // Instruction fields decoded from the latched instruction word
    logic [2:0]   w_op;
    logic [2:0]   w_rd;
    logic [2:0]   w_ra;
    logic [2:0]   w_rb;
    logic [N-1:0] w_imm_ext;
    logic         w_is_alu;
    logic         w_rf_we;
    logic [N-1:0] wb_data_d;

    assign w_op      = ir_q[15:13];
    assign w_rd      = ir_q[12:10];
    assign w_ra      = ir_q[9:7];
    assign w_rb      = ir_q[6:4];
    assign w_imm_ext = {{(N-7){1'b0}}, ir_q[6:0]};
    assign w_is_alu  = (w_op != c_OP_NOP) && (w_op != c_OP_LDI);

    // Write-back source: ALU result for ALU ops, zero-extended immediate for LDI
    always_comb begin
        wb_data_d = result_q;
        w_rf_we   = 1'b0;
        if (w_is_alu) begin
            wb_data_d = result_q;
            w_rf_we   = 1'b1;
        end else if (w_op == c_OP_LDI) begin
            wb_data_d = w_imm_ext;
            w_rf_we   = 1'b1;
        end
    end

    // Control FSM plus the registers it loads (instruction, operands, result, flags)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ir_q     <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            result_q <= '0;
`ifdef FLAGS_EN
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    // instr_ready is high exactly in this state
                    if (bus.instr_valid) begin
                        ir_q    <= bus.instr;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    // Operands are captured here, so rd == ra/rb is harmless
                    alu_a_q  <= rf_q[w_ra];
                    alu_b_q  <= rf_q[w_rb];
                    alu_op_q <= w_op;
                    state_q  <= w_is_alu ? S_EXEC : S_WB;
                end
                S_EXEC: begin
                    result_q <= bus.alu_out;
                    state_q  <= S_WB;
                end
                S_WB: begin
`ifdef FLAGS_EN
                    if (w_is_alu) begin
                        flag_z_q <= (result_q == '0);
                        flag_n_q <= result_q[N-1];
                    end
`endif
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Register file: cleared by reset, written only at the end of WB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if ((state_q == S_WB) && w_rf_we) begin
            rf_q[w_rd] <= wb_data_d;
        end
    end

    assign bus.instr_ready = (state_q == S_IDLE);
    assign bus.alu_en      = (state_q == S_EXEC);
    assign bus.done        = (state_q == S_WB);
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.dbg_data    = rf_q[bus.dbg_addr];
`ifdef FLAGS_EN
    assign bus.flag_z      = flag_z_q;
    assign bus.flag_n      = flag_n_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Self-checking bench for alu_sequencer with a behavioural
//            ALU, a register-file reference model, directed and random
//            instruction streams.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_sequencer_if #(.N(N)) bus ();

    alu_sequencer #(.N(N), .REGS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int last_accept = -1;
    int prev_lat    = 0;

    logic [N-1:0] model_rf [8];
    logic         model_z;
    logic         model_n;
    logic [N-1:0] alu_hold;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: a+b, a-b, and, or, xor, not a
    function automatic logic [N-1:0] alu_f(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        case (op)
            3'b010:  return a + b;
            3'b011:  return a - b;
            3'b100:  return a & b;
            3'b101:  return a | b;
            3'b110:  return a ^ b;
            3'b111:  return ~a;
            default: return a;
        endcase
    endfunction

    // ALU holds its last output while not enabled
    assign bus.alu_out = bus.alu_en ? alu_f(bus.alu_op, bus.alu_a, bus.alu_b) : alu_hold;
    always @(posedge clk or posedge rst) begin
        if (rst) alu_hold <= '0;
        else if (bus.alu_en) alu_hold <= alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [6:0] imm);
        return {3'b001, rd, 3'b000, imm};
    endfunction

    function automatic logic [15:0] aluop(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, ra, rb, 4'b0000};
    endfunction

    // Compare every register through the debug port; ends on a falling edge
    task automatic sweep(input string tag);
        for (int i = 0; i < 8; i++) begin
            bus.dbg_addr = 3'(i);
            #1;
            check(tag, 32'(bus.dbg_data), 32'(model_rf[i]));
        end
        @(negedge clk);
    endtask

    task automatic check_reg(input logic [2:0] r, input logic [N-1:0] v, input string tag);
        bus.dbg_addr = r;
        #1;
        check(tag, 32'(bus.dbg_data), 32'(v));
        @(negedge clk);
    endtask

    // Issue one instruction from a falling edge and follow it to retirement.
    // Returns on the falling edge in the IDLE cycle after WB.
    task automatic do_instr(input logic [15:0] ins, input bit stream);
        logic [2:0]   op, rd, ra, rb;
        logic [N-1:0] exp_a, exp_b, exp_res;
        bit           is_alu;
        int           lat, t;
        op = ins[15:13]; rd = ins[12:10]; ra = ins[9:7]; rb = ins[6:4];
        is_alu = (op >= 3'd2);
        lat    = is_alu ? 3 : 2;
        exp_a  = model_rf[ra];
        exp_b  = model_rf[rb];
        if (is_alu)          exp_res = alu_f(op, exp_a, exp_b);
        else if (op == 3'd1) exp_res = {{(N-7){1'b0}}, ins[6:0]};
        else                 exp_res = model_rf[rd];

        t = 0;
        while (!bus.instr_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("ready_before_accept", 32'(bus.instr_ready), 1);
        if (stream && last_accept >= 0)
            check("accept_spacing", cyc - last_accept, prev_lat + 1);
        last_accept = cyc;
        prev_lat    = lat;
        bus.instr       = ins;
        bus.instr_valid = 1'b1;

        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (stream) bus.instr = 16'($urandom);
            else        bus.instr_valid = 1'b0;
            check("ready_busy", 32'(bus.instr_ready), 0);
            check("alu_en", 32'(bus.alu_en), 32'(is_alu && k == 2));
            check("done", 32'(bus.done), 32'(k == lat));
            if (k == 2) begin
                check("alu_a", 32'(bus.alu_a), 32'(exp_a));
                check("alu_b", 32'(bus.alu_b), 32'(exp_b));
                check("alu_op", 32'(bus.alu_op), 32'(op));
            end
        end
        bus.dbg_addr = rd;
        if (op != 3'd0) model_rf[rd] = exp_res;
        if (is_alu) begin
            model_z = (exp_res == '0);
            model_n = exp_res[N-1];
        end

        @(negedge clk);
        check("ready_idle", 32'(bus.instr_ready), 1);
        check("done_idle", 32'(bus.done), 0);
        check("writeback", 32'(bus.dbg_data), 32'(model_rf[rd]));
`ifdef FLAGS_EN
        check("flag_z", 32'(bus.flag_z), 32'(model_z));
        check("flag_n", 32'(bus.flag_n), 32'(model_n));
`endif
        if (!stream) last_accept = -1;
    endtask

    initial begin
        logic [15:0] r;
        logic [2:0]  sop;
        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        bus.dbg_addr    = '0;
        for (int i = 0; i < 8; i++) model_rf[i] = '0;
        model_z = 1'b0;
        model_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_alu_en", 32'(bus.alu_en), 0);
        check("rst_done", 32'(bus.done), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(bus.instr_ready), 1);
        check("rst_alu_a", 32'(bus.alu_a), 0);
        check("rst_alu_b", 32'(bus.alu_b), 0);
        check("rst_alu_op", 32'(bus.alu_op), 0);
        sweep("rst_rf");

        // LDI r1,#5; LDI r2,#3; ADD r3,r1,r2
        do_instr(ldi(3'd1, 7'd5), 1'b0);
        do_instr(ldi(3'd2, 7'd3), 1'b0);
        do_instr(aluop(3'b010, 3'd3, 3'd1, 3'd2), 1'b0);
        check_reg(3'd3, 16'd8, "add_r3");

        // SUB r4,r2,r1 = 3-5
        do_instr(aluop(3'b011, 3'd4, 3'd2, 3'd1), 1'b0);
        check_reg(3'd4, 16'hFFFE, "sub_r4");
`ifdef FLAGS_EN
        check("sub_flag_n", 32'(bus.flag_n), 1);
        check("sub_flag_z", 32'(bus.flag_z), 0);
`endif

        // NOT r1,r1 then XOR r5,r1,r1
        do_instr(aluop(3'b111, 3'd1, 3'd1, 3'd1), 1'b0);
        check_reg(3'd1, 16'hFFFA, "not_r1");
        do_instr(aluop(3'b110, 3'd5, 3'd1, 3'd1), 1'b0);
        check_reg(3'd5, 16'h0000, "xor_r5");
`ifdef FLAGS_EN
        check("xor_flag_z", 32'(bus.flag_z), 1);
`endif

        // NOP leaves every register unchanged
        do_instr(16'h0000, 1'b0);
        sweep("nop_rf");

        // Back-to-back with instr_valid held high and junk while busy
        for (int i = 0; i < 16; i++) begin
            sop = 3'($urandom_range(1, 7));
            do_instr({sop, 3'($urandom), 3'($urandom), 7'($urandom)}, 1'b1);
        end
        bus.instr_valid = 1'b0;
        last_accept = -1;
        sweep("stream_rf");

        // Fully random instruction words
        for (int i = 0; i < 40; i++) begin
            r = 16'($urandom);
            do_instr(r, 1'b0);
        end
        sweep("random_rf");

        // Reset in the middle of EXEC aborts the instruction
        bus.instr       = aluop(3'b010, 3'd6, 3'd1, 3'd2);
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_exec", 32'(bus.alu_en), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_alu_en", 32'(bus.alu_en), 0);
        check("mid_rst_done", 32'(bus.done), 0);
        for (int i = 0; i < 8; i++) model_rf[i] = '0;
        model_z = 1'b0;
        model_n = 1'b0;
        sweep("mid_rst_rf");
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.instr_ready), 1);
        check("post_rst_done", 32'(bus.done), 0);
        check("post_rst_alu_en", 32'(bus.alu_en), 0);
`ifdef FLAGS_EN
        check("post_rst_flag_z", 32'(bus.flag_z), 0);
        check("post_rst_flag_n", 32'(bus.flag_n), 0);
`endif
        do_instr(ldi(3'd7, 7'h7F), 1'b0);
        sweep("post_rst_rf");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
